// File: rtl/as_pkg.sv
// Shared definitions for the accumulator controller: FSM states, operation
// codes and the signed saturation limits used when AS_ACCUM_SAT_EN is defined.
package as_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Largest signed value for a given width, right-aligned in 64 bits.
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Smallest signed value (MSB only set) for a given width, right-aligned.
    function automatic logic [63:0] sat_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/as_ovf_sat.sv
// Signed-overflow detection for the external adder-subtractor result, plus
// optional saturation of the result. Saturation is built only when the macro
// AS_ACCUM_SAT_EN is defined; otherwise the result wraps around.
module as_ovf_sat
    import as_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    input  logic             op,
    output logic             v,
    output logic [WIDTH-1:0] result
);

    localparam int MSB = WIDTH - 1;

    // Overflow: result sign disagrees with A when the operand signs make that impossible.
    // NOTE: every signal written in always_comb is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        v = 1'b0;
        case (op)
            OP_ADD: v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            OP_SUB: v = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
        endcase
    end

`ifdef AS_ACCUM_SAT_EN
    localparam logic [WIDTH-1:0] LIM_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] LIM_MIN = WIDTH'(sat_min(WIDTH));

    // Clamp towards the sign of A: overflow always runs away from A's sign.
    always_comb begin
        result = sum;
        if (v) begin
            result = a[MSB] ? LIM_MIN : LIM_MAX;
        end
    end
`else
    assign result = sum;
`endif

endmodule

// File: rtl/as_accum_ctrl.sv
// Accumulator controller driving an external adder-subtractor. A request is
// accepted in IDLE; the operand is presented on b_o/cin_o with the
// accumulator on a_o, the sum is allowed SETTLE_CYC cycles to settle, then
// captured with flags and a one-cycle out_valid pulse. A clear request is
// handled directly in IDLE. Define AS_ACCUM_SAT_EN to saturate on overflow.
module as_accum_ctrl
    import as_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_op,
    input  logic             in_clr,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             cin_o,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output logic [WIDTH-1:0] acc,
    output logic             c_flag,
    output logic             v_flag,
    output logic             z_flag,
    output logic             out_valid
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_cnt;
    logic             w_accept;
    logic             w_capture;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic             r_c;
    logic             r_v;
    logic             r_z;
    logic             r_out_valid;
    logic             w_v;
    logic [WIDTH-1:0] w_result;

    // Overflow/saturation on the operands actually presented to the adder.
    as_ovf_sat #(
        .WIDTH (WIDTH)
    ) u_ovf_sat (
        .a      (r_acc),
        .b      (r_b),
        .sum    (sum_i),
        .op     (r_cin),
        .v      (w_v),
        .result (w_result)
    );

    // State register; reset forces IDLE immediately.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, handshake and the accept/capture strobes.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (!in_clr) begin
                        w_state_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (r_cnt == 4'd1) begin
                    w_capture    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand registers, settle counter, accumulator, flags and result pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_cnt       <= 4'd0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_z         <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == SETTLE) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_accept && in_clr) begin
                r_acc       <= '0;
                r_c         <= 1'b0;
                r_v         <= 1'b0;
                r_z         <= 1'b1;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_b   <= in_data;
                r_cin <= in_op;
                r_cnt <= CNT_INIT;
            end
            if (w_capture) begin
                r_acc       <= w_result;
                r_c         <= cout_i;
                r_v         <= w_v;
                r_z         <= (w_result == '0);
                r_out_valid <= 1'b1;
            end
        end
    end

    assign a_o       = r_acc;
    assign b_o       = r_b;
    assign cin_o     = r_cin;
    assign acc       = r_acc;
    assign c_flag    = r_c;
    assign v_flag    = r_v;
    assign z_flag    = r_z;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_as_accum_ctrl.sv
// Self-checking bench for as_accum_ctrl (SETTLE_CYC=3) with an 8-bit
// ripple-carry adder-subtractor attached. Expected results come from an
// integer-arithmetic model of the accumulator; the model also follows
// AS_ACCUM_SAT_EN when that macro is defined.
module tb_as_accum_ctrl;

    localparam int WIDTH  = 8;
    localparam int SETTLE = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_op;
    logic             in_clr;
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic             cin_o;
    logic [WIDTH-1:0] sum_i;
    logic             cout_i;
    logic [WIDTH-1:0] acc;
    logic             c_flag;
    logic             v_flag;
    logic             z_flag;
    logic             out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference accumulator state
    logic [7:0] m_acc;
    logic       m_c;
    logic       m_v;
    logic       m_z;

    as_accum_ctrl #(
        .WIDTH      (WIDTH),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_clr    (in_clr),
        .a_o       (a_o),
        .b_o       (b_o),
        .cin_o     (cin_o),
        .sum_i     (sum_i),
        .cout_i    (cout_i),
        .acc       (acc),
        .c_flag    (c_flag),
        .v_flag    (v_flag),
        .z_flag    (z_flag),
        .out_valid (out_valid)
    );

    // External 8-bit ripple-carry adder-subtractor: B is inverted when Cin=1.
    function automatic logic [8:0] ripple(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [7:0] s;
        logic       c;
        logic       bx;
        c = cin;
        for (int i = 0; i < 8; i++) begin
            bx   = b[i] ^ cin;
            s[i] = a[i] ^ bx ^ c;
            c    = (a[i] & bx) | (c & (a[i] ^ bx));
        end
        return {c, s};
    endfunction

    assign {cout_i, sum_i} = ripple(a_o, b_o, cin_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model update from plain signed/unsigned arithmetic.
    task automatic model_apply(input logic [7:0] d, input logic op, input logic clr);
        int ua, ud, sa, sd, sr, res;
        if (clr) begin
            m_acc = 8'h00; m_c = 1'b0; m_v = 1'b0; m_z = 1'b1;
            return;
        end
        ua = int'(m_acc);
        ud = int'(d);
        sa = (ua > 127) ? ua - 256 : ua;
        sd = (ud > 127) ? ud - 256 : ud;
        if (op == 1'b0) begin
            res = (ua + ud) & 255;
            m_c = (ua + ud) > 255;
            sr  = sa + sd;
        end else begin
            res = (ua - ud) & 255;
            m_c = (ua >= ud);
            sr  = sa - sd;
        end
        m_v = (sr > 127) || (sr < -128);
`ifdef AS_ACCUM_SAT_EN
        if (m_v) res = (sr > 127) ? 127 : 128;
`endif
        m_acc = 8'(res);
        m_z   = (res == 0);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_acc"}, acc, m_acc);
        check({tag, "_a_o"}, a_o, m_acc);
        check({tag, "_c"}, c_flag, m_c);
        check({tag, "_v"}, v_flag, m_v);
        check({tag, "_z"}, z_flag, m_z);
    endtask

    // One request from IDLE; in_valid is held with junk during SETTLE to show it is ignored.
    task automatic do_req(input string tag, input logic [7:0] d, input logic op, input logic clr);
        logic [7:0] a_before;
        a_before = m_acc;
        check({tag, "_ready"}, in_ready, 1'b1);
        in_valid = 1'b1; in_data = d; in_op = op; in_clr = clr;
        @(posedge clk); #1;
        model_apply(d, op, clr);
        if (clr) begin
            in_valid = 1'b0;
            check({tag, "_pulse"}, out_valid, 1'b1);
            check({tag, "_stay_idle"}, in_ready, 1'b1);
        end else begin
            for (int k = 0; k < SETTLE; k++) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom_range(0, 255));
                in_op    = 1'($urandom_range(0, 1));
                in_clr   = 1'($urandom_range(0, 1));
                check({tag, "_busy"}, in_ready, 1'b0);
                check({tag, "_early"}, out_valid, 1'b0);
                check({tag, "_a_hold"}, a_o, a_before);
                check({tag, "_b_hold"}, b_o, d);
                check({tag, "_cin_hold"}, cin_o, op);
                @(posedge clk); #1;
            end
            in_valid = 1'b0; in_clr = 1'b0;
            check({tag, "_pulse"}, out_valid, 1'b1);
            check({tag, "_ready_after"}, in_ready, 1'b1);
        end
        check_result(tag);
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, out_valid, 1'b0);
        check({tag, "_acc_hold"}, acc, m_acc);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = 1'b0; in_clr = 1'b0;
        m_acc = 8'h00; m_c = 1'b0; m_v = 1'b0; m_z = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", acc, 8'h00);
        check("rst_a_o", a_o, 8'h00);
        check("rst_b_o", b_o, 8'h00);
        check("rst_cin", cin_o, 1'b0);
        check("rst_flags", {c_flag, v_flag, z_flag}, 3'b001);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with literal expectations alongside the model
        do_req("add3", 8'h03, 1'b0, 1'b0);
        check("add3_lit", {acc, c_flag, v_flag, z_flag}, {8'h03, 3'b000});
        do_req("sub1", 8'h01, 1'b1, 1'b0);
        check("sub1_lit", {acc, c_flag, v_flag}, {8'h02, 2'b10});
        do_req("clr_a", 8'h00, 1'b0, 1'b1);
        do_req("load7f", 8'h7F, 1'b0, 1'b0);
        do_req("ovf", 8'h01, 1'b0, 1'b0);
`ifdef AS_ACCUM_SAT_EN
        check("ovf_lit", {acc, v_flag}, {8'h7F, 1'b1});
`else
        check("ovf_lit", {acc, v_flag}, {8'h80, 1'b1});
`endif
        do_req("clr_b", 8'h00, 1'b0, 1'b1);
        do_req("borrow", 8'h01, 1'b1, 1'b0);
        check("borrow_lit", {acc, c_flag, v_flag, z_flag}, {8'hFF, 3'b000});
        do_req("clr55", 8'h55, 1'b1, 1'b1);
        check("clr55_lit", {acc, z_flag}, {8'h00, 1'b1});

        // Reset in the 2nd SETTLE cycle aborts the operation
        do_req("pre_rst", 8'h22, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h10; in_op = 1'b0; in_clr = 1'b0;
        @(posedge clk); #1;
        check("ab_busy1", in_ready, 1'b0);
        @(posedge clk); #1;
        check("ab_busy2", in_ready, 1'b0);
        check("ab_b_o", b_o, 8'h10);
        #2 rst = 1'b1;
        #1;
        check("ab_acc", acc, 8'h00);
        check("ab_ready_async", in_ready, 1'b1);
        for (int k = 0; k < SETTLE; k++) begin
            @(posedge clk); #1;
            check("ab_no_pulse", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        m_acc = 8'h00; m_c = 1'b0; m_v = 1'b0; m_z = 1'b1;
        @(posedge clk); #1;
        check("ab_ready_rel", in_ready, 1'b1);
        check("ab_no_pulse_rel", out_valid, 1'b0);
        check_result("ab_state");

        // Randomized traffic with occasional idle gaps
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       op;
            logic       clr;
            d   = 8'($urandom_range(0, 255));
            op  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            do_req("rnd", d, op, clr);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                check("gap_no_pulse", out_valid, 1'b0);
                check_result("gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/as_accum_ctrl.md
AS_ACCUM_CTRL -- requirements
Module: as_accum_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand and accumulator width.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 1, range 1-15, the cycles the adder-subtractor output is allowed to settle before capture.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, the rising-edge clock; rst input 1, the reset.
REQ-004 The block SHALL have these handshake inputs: in_valid input 1, request present; in_ready output 1, request accepted when high with in_valid.
REQ-005 The block SHALL have these request fields: in_data input WIDTH, operand; in_op input 1, 0=add, 1=subtract; in_clr input 1, clear accumulator.
REQ-006 The block SHALL have these adder-subtractor side ports: a_o output WIDTH, to adder A; b_o output WIDTH, to adder B; cin_o output 1, to adder Cin (1 = subtract).
REQ-007 The block SHALL have these adder-subtractor returns: sum_i input WIDTH, from adder Sum; cout_i input 1, from adder Cout.
REQ-008 The block SHALL have these result outputs: acc output WIDTH, accumulator; c_flag output 1, carry / no-borrow; v_flag output 1, signed overflow; z_flag output 1, acc==0; out_valid output 1, one-cycle result pulse.

Function
REQ-009 The FSM SHALL have the states IDLE and SETTLE; in_ready SHALL be 1 only in IDLE.
REQ-010 In IDLE, an accepted request with in_clr=1 SHALL set acc=0, c_flag=0, v_flag=0, z_flag=1, and pulse out_valid the next cycle, staying in IDLE; in_clr SHALL override in_op and in_data.
REQ-011 In IDLE, an accepted request with in_clr=0 SHALL register b_o<=in_data and cin_o<=in_op, load the settle counter with SETTLE_CYC, and enter SETTLE.
REQ-012 a_o SHALL equal acc at all times; a_o, b_o and cin_o SHALL be register outputs that are stable throughout SETTLE.
REQ-013 SETTLE SHALL decrement the counter each cycle; on the edge where the counter equals 1, the block SHALL capture sum_i into acc, capture cout_i into c_flag, compute v_flag and z_flag, return to IDLE, and assert out_valid for exactly the following cycle.
REQ-014 Latency SHALL be as follows: with acceptance at edge E, updated acc and out_valid=1 appear after edge E+SETTLE_CYC, and the next request is accepted no earlier than that cycle.
REQ-015 v_flag SHALL be computed as follows: for add, a[MSB]==b[MSB] and sum[MSB]!=a[MSB]; for subtract, a[MSB]!=b[MSB] and sum[MSB]!=a[MSB].
REQ-016 Subtract carry SHALL follow the adder convention: cout_i=1 means no borrow.
REQ-017 in_valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-018 Outputs SHALL hold their values in IDLE between results; out_valid SHALL be 0 except during the defined pulse.

Reset
REQ-019 rst=1 SHALL asynchronously force IDLE; acc, a_o, b_o, cin_o, c_flag, v_flag and out_valid SHALL all be 0, z_flag SHALL be 1, and the counter SHALL be 0.
REQ-020 Reset during SETTLE SHALL abort the operation with no out_valid pulse; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-021 With macro AS_ACCUM_SAT_EN defined, a captured result with v_flag=1 SHALL set acc to the signed maximum (0x7F for WIDTH=8) if a[MSB]=0, or to the signed minimum (0x80) otherwise; v_flag SHALL still be 1, and z_flag SHALL be computed from the saturated value.
REQ-022 Without AS_ACCUM_SAT_EN, acc SHALL take sum_i unmodified (wrap-around).

Structure
REQ-023 Shared package as_pkg SHALL hold the FSM state enum (IDLE, SETTLE), OP_ADD=0/OP_SUB=1, and the saturation-limit functions of WIDTH.
REQ-024 Overflow detection and saturation SHALL be a combinational sub-module as_ovf_sat (inputs a, b, sum, op; outputs v, result).
REQ-025 The adder-subtractor itself SHALL be instantiated outside this block; the bench SHALL connect an 8-bit ripple-carry adder-subtractor to a_o/b_o/cin_o/sum_i/cout_i.

Verification
REQ-026 Reset, then add 0x03 -> acc=0x03, c=0, v=0, z=0, one out_valid pulse after SETTLE_CYC edges.
REQ-027 From acc=0x03, subtract 0x01 -> acc=0x02, c=1, v=0.
REQ-028 From acc=0x7F, add 0x01 -> without macro acc=0x80, v=1; with macro acc=0x7F, v=1.
REQ-029 From acc=0x00, subtract 0x01 -> acc=0xFF, c=0, v=0, z=0.
REQ-030 With SETTLE_CYC=3, assert rst in the 2nd SETTLE cycle -> acc=0x00, no out_valid pulse, in_ready=1 after release; in_valid held during SETTLE is not accepted.
REQ-031 Request with in_clr=1, in_op=1, in_data=0x55 -> acc=0x00, z=1, out_valid pulse in the next cycle, SETTLE never entered.
